// File: rtl/spike_rate_meter.sv
// Turns the neuron's spike level into a windowed rate, the last inter-spike interval
// and a pulse-stretched LED drive. All outputs are registered; enable=0 freezes measurement.
module spike_rate_meter #(
  parameter logic [23:0] WINDOW_CYCLES = 24'd10_000_000,
  parameter int          CNT_W         = 8,
  parameter int          ISI_W         = 16,
  parameter logic [23:0] STRETCH       = 24'd1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike,
  input  logic             enable,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic             overflow,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid,
  output logic             led
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ISI_W-1:0] ISI_MAX  = '1;
  localparam logic [ISI_W-1:0] ISI_ONE  = {{(ISI_W-1){1'b0}}, 1'b1};
  localparam logic [23:0]      WIN_LAST = WINDOW_CYCLES - 24'd1;

  typedef enum logic {IDLE, MEASURE} isi_state_t;

  isi_state_t       state, state_nxt;
  logic             spike_d;
  logic             spike_edge;
  logic [23:0]      win_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic             run_ovf;
  logic [ISI_W-1:0] isi_cnt;
  logic [23:0]      stretch_cnt;

  logic             cnt_clip;
  logic [CNT_W-1:0] cnt_sum;
  logic             cnt_ovf;
  logic             isi_start;
  logic             isi_capture;
  logic [23:0]      stretch_nxt;

  assign spike_edge = spike & ~spike_d;

  // overflow means an edge was actually lost to clipping, not merely that the count hit max
  always_comb begin
    cnt_clip = spike_edge && (run_cnt == CNT_MAX);
    cnt_sum  = cnt_clip ? run_cnt : run_cnt + {{(CNT_W-1){1'b0}}, spike_edge};
    cnt_ovf  = run_ovf | cnt_clip;
  end

  always_comb begin
    stretch_nxt = stretch_cnt;
    if (spike_edge)
      stretch_nxt = STRETCH;
    else if (stretch_cnt != 24'd0)
      stretch_nxt = stretch_cnt - 24'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    isi_start   = 1'b0;
    isi_capture = 1'b0;
    if (enable && spike_edge) begin
      case (state)
        IDLE: begin
          isi_start = 1'b1;
          state_nxt = MEASURE;
        end
        MEASURE: isi_capture = 1'b1;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spike_d     <= 1'b0;
      win_cnt     <= 24'd0;
      run_cnt     <= '0;
      run_ovf     <= 1'b0;
      isi_cnt     <= '0;
      stretch_cnt <= 24'd0;
      rate        <= '0;
      rate_valid  <= 1'b0;
      overflow    <= 1'b0;
      isi         <= '0;
      isi_valid   <= 1'b0;
      led         <= 1'b0;
    end else begin
      spike_d    <= spike;
      rate_valid <= 1'b0;
      isi_valid  <= 1'b0;
      if (enable) begin
        // a terminal-cycle edge is folded into the closing window's result
        if (win_cnt == WIN_LAST) begin
          win_cnt    <= 24'd0;
          rate       <= cnt_sum;
          overflow   <= cnt_ovf;
          rate_valid <= 1'b1;
          run_cnt    <= '0;
          run_ovf    <= 1'b0;
        end else begin
          win_cnt <= win_cnt + 24'd1;
          run_cnt <= cnt_sum;
          run_ovf <= cnt_ovf;
        end

        if (isi_start) begin
          isi_cnt <= ISI_ONE;
        end else if (isi_capture) begin
          isi       <= isi_cnt;
          isi_valid <= 1'b1;
          isi_cnt   <= ISI_ONE;
        end else if (state == MEASURE && isi_cnt != ISI_MAX) begin
          isi_cnt <= isi_cnt + ISI_ONE;
        end

        stretch_cnt <= stretch_nxt;
        led         <= (stretch_nxt != 24'd0);
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_meter.sv
// Directed bench for spike_rate_meter with a 20-cycle window, 4-bit count/ISI and 4-cycle LED stretch.
module tb_spike_rate_meter;

  logic       clk = 1'b0;
  logic       reset;
  logic       spike;
  logic       enable;
  logic [3:0] rate;
  logic       rate_valid;
  logic       overflow;
  logic [3:0] isi;
  logic       isi_valid;
  logic       led;

  int tests = 0;
  int fails = 0;
  int rv_cnt = 0;
  int iv_cnt = 0;
  int rv_mark;
  int iv_mark;

  spike_rate_meter #(
    .WINDOW_CYCLES(24'd20),
    .CNT_W        (4),
    .ISI_W        (4),
    .STRETCH      (24'd4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .spike     (spike),
    .enable    (enable),
    .rate      (rate),
    .rate_valid(rate_valid),
    .overflow  (overflow),
    .isi       (isi),
    .isi_valid (isi_valid),
    .led       (led)
  );

  always #5 clk = ~clk;

  // apply inputs for one clock edge, then observe just after it
  task automatic tick(input logic sp, input logic en);
    spike  = sp;
    enable = en;
    @(posedge clk);
    #1;
    if (rate_valid === 1'b1) rv_cnt++;
    if (isi_valid === 1'b1) iv_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rate"}, 32'(rate), 32'd0);
    check({tag, "_rate_valid"}, 32'(rate_valid), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_isi"}, 32'(isi), 32'd0);
    check({tag, "_isi_valid"}, 32'(isi_valid), 32'd0);
    check({tag, "_led"}, 32'(led), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    spike  = 1'b0;
    enable = 1'b0;
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    check_all_zero("reset");
    reset = 1'b0;

    // window 1: edges at 1,4,7,10,13
    for (int i = 0; i < 20; i++) begin
      tick((i == 1 || i == 4 || i == 7 || i == 10 || i == 13), 1'b1);
      if (i == 18) check("w1_no_early_valid", 32'(rate_valid), 32'd0);
    end
    check("w1_rate", 32'(rate), 32'd5);
    check("w1_rate_valid", 32'(rate_valid), 32'd1);
    check("w1_overflow", 32'(overflow), 32'd0);
    check("w1_valid_count", 32'(rv_cnt), 32'd1);
    check("w1_isi", 32'(isi), 32'd3);
    tick(1'b0, 1'b1);
    check("w1_valid_one_cycle", 32'(rate_valid), 32'd0);
    check("w1_rate_hold", 32'(rate), 32'd5);

    // window 2: toggling, 10 edges, last one on the terminal cycle
    for (int j = 0; j < 19; j++) begin
      tick((j % 2 == 0), 1'b1);
      if (j == 17) check("w2_rate_before_terminal", 32'(rate), 32'd5);
    end
    check("w2_rate_terminal_edge", 32'(rate), 32'd10);
    check("w2_overflow", 32'(overflow), 32'd0);
    check("w2_rate_valid", 32'(rate_valid), 32'd1);

    // window 3: 18 edges via enable gating so every window cycle can rise
    for (int w = 0; w < 20; w++) begin
      if (w < 18) begin
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
      end else begin
        tick(1'b0, 1'b1);
      end
    end
    check("w3_rate_saturated", 32'(rate), 32'd15);
    check("w3_overflow", 32'(overflow), 32'd1);
    check("w3_rate_valid", 32'(rate_valid), 32'd1);

    // window 4: starts from zero, 10 disabled cycles with spikes in the middle
    for (int i = 0; i < 5; i++) tick((i == 1), 1'b1);
    rv_mark = rv_cnt;
    iv_mark = iv_cnt;
    for (int i = 0; i < 10; i++) tick((i % 2 == 0), 1'b0);
    check("gate_no_rate_valid", 32'(rv_cnt - rv_mark), 32'd0);
    check("gate_no_isi_valid", 32'(iv_cnt - iv_mark), 32'd0);
    check("gate_rate_hold", 32'(rate), 32'd15);
    check("gate_overflow_hold", 32'(overflow), 32'd1);
    for (int k = 0; k < 15; k++) begin
      tick((k == 2), 1'b1);
      if (k == 13) check("gate_window_extended", 32'(rv_cnt - rv_mark), 32'd0);
    end
    check("w4_rate", 32'(rate), 32'd2);
    check("w4_overflow", 32'(overflow), 32'd0);
    check("w4_rate_valid", 32'(rate_valid), 32'd1);

    // reset mid-window with count 3 and ISI measuring
    for (int i = 0; i < 10; i++) tick((i == 1 || i == 4 || i == 7), 1'b1);
    reset = 1'b1;
    tick(1'b1, 1'b1);
    check_all_zero("midreset");
    reset  = 1'b0;
    iv_cnt = 0;

    // post-reset: edges at 3, 10, 30, each spike held 3 cycles
    for (int c = 0; c < 40; c++) begin
      tick(((c >= 3 && c <= 5) || (c >= 10 && c <= 12) || (c >= 30 && c <= 32)), 1'b1);
      if (c == 3) begin
        check("isi_first_edge_no_valid", 32'(isi_valid), 32'd0);
        check("isi_first_edge_isi", 32'(isi), 32'd0);
      end
      if (c == 10) begin
        check("isi_7_valid", 32'(isi_valid), 32'd1);
        check("isi_7", 32'(isi), 32'd7);
      end
      if (c == 19) begin
        check("post_reset_rate", 32'(rate), 32'd2);
        check("post_reset_rate_valid", 32'(rate_valid), 32'd1);
        check("post_reset_overflow", 32'(overflow), 32'd0);
      end
      if (c == 30) begin
        check("isi_sat_valid", 32'(isi_valid), 32'd1);
        check("isi_sat", 32'(isi), 32'd15);
      end
    end
    check("isi_valid_count", 32'(iv_cnt), 32'd2);
    check("post_reset_rate_w2", 32'(rate), 32'd1);
    check("led_idle", 32'(led), 32'd0);

    // LED: isolated edge gives exactly 4 cycles
    tick(1'b1, 1'b1); check("led_single_0", 32'(led), 32'd1);
    tick(1'b0, 1'b1); check("led_single_1", 32'(led), 32'd1);
    tick(1'b0, 1'b1); check("led_single_2", 32'(led), 32'd1);
    tick(1'b0, 1'b1); check("led_single_3", 32'(led), 32'd1);
    tick(1'b0, 1'b1); check("led_single_off", 32'(led), 32'd0);

    // LED retrigger: second edge 2 cycles later extends to 4 past it
    tick(1'b1, 1'b1); check("led_re_0", 32'(led), 32'd1);
    tick(1'b0, 1'b1); check("led_re_1", 32'(led), 32'd1);
    tick(1'b1, 1'b1); check("led_re_2", 32'(led), 32'd1);
    tick(1'b0, 1'b1); check("led_re_3", 32'(led), 32'd1);
    tick(1'b0, 1'b1); check("led_re_4", 32'(led), 32'd1);
    tick(1'b0, 1'b1); check("led_re_5", 32'(led), 32'd1);
    tick(1'b0, 1'b1); check("led_re_off", 32'(led), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
